rriot_timer_master: RTL and testbench

- Bus initiator for the RRIOT interval timer.
- Accepts a command (count, prescale, irq enable, completion mode), performs the write cycle that arms the timer, then waits for completion by IRQ or by polling reads.
- Reports the final timer readback, a timeout flag and a bus-error flag.
- Used by the on-chip self-test sequencer and the FPGA bring-up harness in place of the 6502 core.

---
 rtl/rriot_timer_master.sv | 226 ++++++++++++++++++++++
 tb/tb_rriot_timer_master.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rriot_timer_master.sv
// Bus initiator that arms the RRIOT interval timer and waits for IRQ or poll completion.
// Optional abort input enabled by defining RRIOT_MASTER_ABORT_EN.
module rriot_timer_master #(
  parameter int unsigned POLL_GAP       = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_count,
  input  logic [1:0] cmd_div,
  input  logic       cmd_irq_en,
  input  logic       cmd_poll,
  output logic       bus_enable,
  output logic       bus_we_n,
  output logic [2:0] bus_a,
  output logic [7:0] bus_wdata,
  input  logic [7:0] bus_rdata,
  input  logic       bus_oe,
  input  logic       bus_irq_n,
`ifdef RRIOT_MASTER_ABORT_EN
  input  logic       abort,
`endif
  output logic       done,
  output logic [7:0] result,
  output logic       timed_out,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WAIT,
    S_GAP,
    S_RD_REQ,
    S_RD_CAP,
    S_DONE
  } state_e;

  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);
  // Counter has already reached TIMEOUT_CYCLES-1 once it increments past this.
  localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd2;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  div_q, div_d;
  logic        ien_q, ien_d;
  logic        poll_q, poll_d;
  logic [23:0] tmo_q, tmo_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0]  prev_q, prev_d;
  logic        abt_q, abt_d;
  logic        to_q, to_d;
  logic        err_q, err_d;
  logic [7:0]  res_q, res_d;
  logic        ben_q, ben_d;
  logic        bwe_n_q, bwe_n_d;
  logic [2:0]  ba_q, ba_d;
  logic [7:0]  bwd_q, bwd_d;
  logic        abort_w;
  logic        tmo_hit;

`ifdef RRIOT_MASTER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign tmo_hit = (tmo_q >= TMO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    ien_d   = ien_q;
    poll_d  = poll_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    prev_d  = prev_q;
    abt_d   = abt_q;
    to_d    = to_q;
    err_d   = err_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          cnt_d   = cmd_count;
          div_d   = cmd_div;
          ien_d   = cmd_irq_en;
          poll_d  = cmd_poll;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        tmo_d   = '0;
        gap_d   = '0;
        prev_d  = 8'hFF;
        abt_d   = 1'b0;
        to_d    = 1'b0;
        err_d   = 1'b0;
        state_d = poll_q ? S_GAP : S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + 24'd1;
        if (!bus_irq_n) begin
          state_d = S_RD_REQ;
        end else if (tmo_hit) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else if (abort_w) begin
          abt_d   = 1'b1;
          state_d = S_RD_REQ;
        end
      end
      S_GAP: begin
        tmo_d = tmo_q + 24'd1;
        if (tmo_hit) begin
          to_d    = 1'b1;
          state_d = S_DONE;
        end else if (abort_w) begin
          abt_d   = 1'b1;
          state_d = S_RD_REQ;
        end else if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_RD_REQ: begin
        tmo_d   = tmo_q + 24'd1;
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        tmo_d = tmo_q + 24'd1;
        if (!bus_oe) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          res_d = bus_rdata;
          if (abt_q) begin
            to_d    = 1'b1;
            state_d = S_DONE;
          end else if (!poll_q) begin
            state_d = S_DONE;
          end else if (bus_rdata == 8'h00 || bus_rdata > prev_q) begin
            state_d = S_DONE;
          end else begin
            prev_d  = bus_rdata;
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state so they appear registered.
  always_comb begin
    ben_d   = 1'b0;
    bwe_n_d = 1'b1;
    ba_d    = '0;
    bwd_d   = '0;
    if (state_d == S_WRITE) begin
      ben_d   = 1'b1;
      bwe_n_d = 1'b0;
      ba_d    = {ien_d, div_d};
      bwd_d   = cnt_d;
    end else if (state_d == S_RD_REQ) begin
      ben_d = 1'b1;
      ba_d  = {ien_q, 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      ien_q   <= 1'b0;
      poll_q  <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
      prev_q  <= 8'hFF;
      abt_q   <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      ben_q   <= 1'b0;
      bwe_n_q <= 1'b1;
      ba_q    <= '0;
      bwd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ien_q   <= ien_d;
      poll_q  <= poll_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      prev_q  <= prev_d;
      abt_q   <= abt_d;
      to_q    <= to_d;
      err_q   <= err_d;
      res_q   <= res_d;
      ben_q   <= ben_d;
      bwe_n_q <= bwe_n_d;
      ba_q    <= ba_d;
      bwd_q   <= bwd_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign result     = res_q;
  assign timed_out  = to_q;
  assign bus_err    = err_q;
  assign bus_enable = ben_q;
  assign bus_we_n   = bwe_n_q;
  assign bus_a      = ba_q;
  assign bus_wdata  = bwd_q;

endmodule

// File: tb/tb_rriot_timer_master.sv
// Directed bench for rriot_timer_master with a small in-line timer responder.
// POLL_GAP=2, TIMEOUT_CYCLES=50.
module tb_rriot_timer_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_count;
  logic [1:0] cmd_div;
  logic       cmd_irq_en;
  logic       cmd_poll;
  logic       bus_enable;
  logic       bus_we_n;
  logic [2:0] bus_a;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_oe;
  logic       bus_irq_n;
  logic       done;
  logic [7:0] result;
  logic       timed_out;
  logic       bus_err;
`ifdef RRIOT_MASTER_ABORT_EN
  logic       abort;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] rdq[$];
  logic       oe_next;

  int         nrd, tdone;
  logic [2:0] wa, ra;
  logic [7:0] wd;
  logic       wr;

  rriot_timer_master #(
    .POLL_GAP(2),
    .TIMEOUT_CYCLES(24'd50)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_count(cmd_count),
    .cmd_div(cmd_div),
    .cmd_irq_en(cmd_irq_en),
    .cmd_poll(cmd_poll),
    .bus_enable(bus_enable),
    .bus_we_n(bus_we_n),
    .bus_a(bus_a),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_oe(bus_oe),
    .bus_irq_n(bus_irq_n),
`ifdef RRIOT_MASTER_ABORT_EN
    .abort(abort),
`endif
    .done(done),
    .result(result),
    .timed_out(timed_out),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in IDLE; returns with the DUT in its WRITE cycle.
  task automatic run_cmd(input logic [7:0] cnt, input logic [1:0] dv,
                         input logic ie, input logic pl, input logic hold,
                         output logic [2:0] a, output logic [7:0] d,
                         output logic w);
    cmd_valid  = 1'b1;
    cmd_count  = cnt;
    cmd_div    = dv;
    cmd_irq_en = ie;
    cmd_poll   = pl;
    tick();
    a = bus_a;
    d = bus_wdata;
    w = bus_enable & ~bus_we_n;
    if (!hold) cmd_valid = 1'b0;
    cmd_count = 8'hAA;
    cmd_div   = 2'b00;
  endtask

  // Cycle 0 is the WRITE cycle; acts as the timer for reads and IRQ.
  task automatic wait_done(input int irq_at, input int abort_at,
                           output int n, output int t,
                           output logic [2:0] a);
    n = 0;
    t = -1;
    a = '0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done) begin
        t = c;
        break;
      end
      if (irq_at > 0 && c >= irq_at) bus_irq_n = 1'b0;
`ifdef RRIOT_MASTER_ABORT_EN
      if (abort_at > 0 && c == abort_at) abort = 1'b1;
`endif
      if (bus_enable && bus_we_n) begin
        n++;
        a = bus_a;
`ifdef RRIOT_MASTER_ABORT_EN
        abort = 1'b0;
`endif
        bus_rdata = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
        bus_oe    = oe_next;
      end
    end
    bus_irq_n = 1'b1;
`ifdef RRIOT_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    if (abort_at < 0) n = -1;
    chk("done_seen", 32'(t > 0), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_count  = '0;
    cmd_div    = '0;
    cmd_irq_en = 1'b0;
    cmd_poll   = 1'b0;
    bus_rdata  = '0;
    bus_oe     = 1'b0;
    bus_irq_n  = 1'b1;
    oe_next    = 1'b1;
`ifdef RRIOT_MASTER_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_en", bus_enable, 0);
    chk("rst_we_n", bus_we_n, 1);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    rst_n = 1'b1;
    tick();

    // IRQ mode, IRQ after 6 cycles, timer returns FF
    rdq = '{8'hFF};
    run_cmd(8'd5, 2'b00, 1'b1, 1'b0, 1'b0, wa, wd, wr);
    chk("irq_wr", wr, 1);
    chk("irq_wa", wa, 3'b100);
    chk("irq_wd", wd, 8'd5);
    wait_done(6, 0, nrd, tdone, ra);
    chk("irq_tdone", tdone, 9);
    chk("irq_nrd", nrd, 1);
    chk("irq_ra", ra, 3'b100);
    chk("irq_res", result, 8'hFF);
    chk("irq_to", timed_out, 0);
    chk("irq_err", bus_err, 0);
    tick();
    chk("irq_ready", cmd_ready, 1);
    chk("irq_done_lo", done, 0);

    // Reset held 3 cycles in the middle of WAIT
    run_cmd(8'd9, 2'b01, 1'b1, 1'b0, 1'b0, wa, wd, wr);
    repeat (4) tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_en", bus_enable, 0);
      chk("mrst_ready", cmd_ready, 1);
      chk("mrst_done", done, 0);
    end
    chk("mrst_res", result, 0);
    chk("mrst_a", bus_a, 0);
    chk("mrst_wd", bus_wdata, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mrst_quiet", bus_enable, 0);

    // Poll mode, counts down 2,1,0
    rdq = '{8'd2, 8'd1, 8'd0};
    run_cmd(8'd3, 2'b01, 1'b0, 1'b1, 1'b0, wa, wd, wr);
    chk("poll_wa", wa, 3'b001);
    chk("poll_wd", wd, 8'd3);
    wait_done(0, 0, nrd, tdone, ra);
    chk("poll_nrd", nrd, 3);
    chk("poll_tdone", tdone, 13);
    chk("poll_ra", ra, 3'b000);
    chk("poll_res", result, 8'h00);
    chk("poll_to", timed_out, 0);
    tick();

    // Poll mode, wrap past zero
    rdq = '{8'd2, 8'hFE};
    run_cmd(8'd3, 2'b00, 1'b0, 1'b1, 1'b0, wa, wd, wr);
    wait_done(0, 0, nrd, tdone, ra);
    chk("wrap_nrd", nrd, 2);
    chk("wrap_tdone", tdone, 9);
    chk("wrap_res", result, 8'hFE);
    tick();

    // Read with no responder drive
    oe_next = 1'b0;
    rdq = '{8'h33};
    run_cmd(8'd7, 2'b11, 1'b1, 1'b0, 1'b0, wa, wd, wr);
    chk("err_wa", wa, 3'b111);
    wait_done(2, 0, nrd, tdone, ra);
    chk("err_tdone", tdone, 5);
    chk("err_flag", bus_err, 1);
    chk("err_res", result, 8'hFE);
    chk("err_to", timed_out, 0);
    oe_next = 1'b1;
    tick();

    // IRQ never arrives
    run_cmd(8'd1, 2'b10, 1'b0, 1'b0, 1'b0, wa, wd, wr);
    chk("tmo_wa", wa, 3'b010);
    wait_done(0, 0, nrd, tdone, ra);
    chk("tmo_tdone", tdone, 50);
    chk("tmo_nrd", nrd, 0);
    chk("tmo_flag", timed_out, 1);
    chk("tmo_err", bus_err, 0);
    chk("tmo_res", result, 8'hFE);
    tick();

    // Back-to-back with cmd_valid held high
    rdq = '{8'd0, 8'd0};
    run_cmd(8'd4, 2'b00, 1'b0, 1'b1, 1'b1, wa, wd, wr);
    wait_done(0, 0, nrd, tdone, ra);
    chk("b2b_tdone", tdone, 5);
    tick();
    chk("b2b_ready", cmd_ready, 1);
    chk("b2b_idle_en", bus_enable, 0);
    tick();
    chk("b2b_wr", bus_enable & ~bus_we_n, 1);
    cmd_valid = 1'b0;
    wait_done(0, 0, nrd, tdone, ra);
    chk("b2b2_tdone", tdone, 5);
    chk("b2b2_nrd", nrd, 1);
    tick();

`ifdef RRIOT_MASTER_ABORT_EN
    // Abort during GAP
    rdq = '{8'd5};
    run_cmd(8'd9, 2'b00, 1'b1, 1'b1, 1'b0, wa, wd, wr);
    wait_done(0, 1, nrd, tdone, ra);
    chk("abt_nrd", nrd, 1);
    chk("abt_tdone", tdone, 4);
    chk("abt_to", timed_out, 1);
    chk("abt_res", result, 8'd5);
    chk("abt_ra", ra, 3'b100);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
